// File: rtl/axis_traffic_gen_pkg.sv
// -----------------------------------------------------------------------------
// axis_traffic_gen_pkg
//   Shared types and helpers for the AXI-Stream traffic generator.
//   - tg_state_t   : generator FSM state encoding (IDLE, SEND, GAP)
//   - MAX_LEN_WIDTH: widest packet-length field the helper below accepts
//   - MIN_PKT_LEN  : shortest legal packet; a zero length config maps to this
//   - eff_len()    : effective packet length, max(len, MIN_PKT_LEN)
// -----------------------------------------------------------------------------
package axis_traffic_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tg_state_t;

  localparam int unsigned MAX_LEN_WIDTH = 32;
  localparam int unsigned MIN_PKT_LEN   = 1;

  // A zero-length packet has no beat to carry tlast, so it is promoted to one word.
  function automatic logic [MAX_LEN_WIDTH-1:0] eff_len(input logic [MAX_LEN_WIDTH-1:0] len);
    return (len == '0) ? MAX_LEN_WIDTH'(MIN_PKT_LEN) : len;
  endfunction

endpackage

// File: rtl/axis_traffic_gen.sv
// -----------------------------------------------------------------------------
// axis_traffic_gen
//   AXI-Stream packet source. On a start pulse it emits a run of fixed-length
//   packets framed with tlast, carrying a free-running incrementing word count,
//   with a configurable number of idle cycles between packets. Fully
//   ready/valid compliant, so downstream backpressure stalls it losslessly.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : one-cycle pulse that begins a run (ignored while busy)
//   stop              : requests a graceful end of run after the current packet
//   cfg_pkt_len       : words per packet (0 behaves as 1)
//   cfg_pkt_num       : packets per run (0 = run until stop)
//   cfg_gap           : idle cycles between packets
//   busy              : run in progress
//   done              : one-cycle pulse in the first idle cycle after a run
//   pkt_cnt           : packets completed in the current/last run
//   m_axis_*          : AXI-Stream master interface
// -----------------------------------------------------------------------------
module axis_traffic_gen
  import axis_traffic_gen_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int LEN_WIDTH = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [LEN_WIDTH-1:0] cfg_pkt_len,
  input  logic [CNT_WIDTH-1:0] cfg_pkt_num,
  input  logic [LEN_WIDTH-1:0] cfg_gap,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic [DWIDTH-1:0]    m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast
);

  tg_state_t            state;
  logic [LEN_WIDTH-1:0] last_beat_q;
  logic [LEN_WIDTH-1:0] gap_q;
  logic [CNT_WIDTH-1:0] pkt_num_q;
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic [LEN_WIDTH-1:0] gap_cnt;
  logic                 stop_pending;

  logic [LEN_WIDTH-1:0] cfg_last_beat;
  logic                 handshake;
  logic                 stop_req;
  logic                 count_reached;
  logic                 run_end;
  logic                 gap_end;

  // Index of the tlast beat, derived from the effective (never zero) length.
  assign cfg_last_beat = LEN_WIDTH'(eff_len(MAX_LEN_WIDTH'(cfg_pkt_len)) - MAX_LEN_WIDTH'(1));

  assign handshake = m_axis_tvalid & m_axis_tready;

  // A stop arriving in the same cycle as the closing handshake still counts,
  // so the run never sends one packet more than needed after a stop.
  assign stop_req = stop_pending | stop;

  // Compared one bit wider so the packet that reaches an all-ones count matches exactly.
  assign count_reached = (pkt_num_q != '0) &&
                         (({1'b0, pkt_cnt} + (CNT_WIDTH+1)'(1)) == {1'b0, pkt_num_q});

  assign run_end = count_reached | stop_req;
  assign gap_end = (gap_cnt == (gap_q - LEN_WIDTH'(1)));

  // Single FSM owning every output register. tdata doubles as the word counter:
  // it only advances on a handshake, which keeps data held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_beat_q   <= '0;
      gap_q         <= '0;
      pkt_num_q     <= '0;
      beat_cnt      <= '0;
      gap_cnt       <= '0;
      stop_pending  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pkt_cnt       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            last_beat_q   <= cfg_last_beat;
            gap_q         <= cfg_gap;
            pkt_num_q     <= cfg_pkt_num;
            pkt_cnt       <= '0;
            beat_cnt      <= '0;
            gap_cnt       <= '0;
            m_axis_tdata  <= '0;
            stop_pending  <= stop;
            busy          <= 1'b1;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (cfg_last_beat == '0);
            state         <= SEND;
          end
        end

        SEND: begin
          if (stop) begin
            stop_pending <= 1'b1;
          end
          if (handshake) begin
            m_axis_tdata <= m_axis_tdata + DWIDTH'(1);
            if (m_axis_tlast) begin
              beat_cnt <= '0;
              // Saturates only matters in unbounded runs; bounded runs end first.
              if (pkt_cnt != '1) begin
                pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
              end
              if (run_end) begin
                state         <= IDLE;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                busy          <= 1'b0;
                done          <= 1'b1;
                stop_pending  <= 1'b0;
              end else if (gap_q == '0) begin
                m_axis_tlast <= (last_beat_q == '0);
              end else begin
                state         <= GAP;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                gap_cnt       <= '0;
              end
            end else begin
              beat_cnt     <= beat_cnt + LEN_WIDTH'(1);
              m_axis_tlast <= ((beat_cnt + LEN_WIDTH'(1)) == last_beat_q);
            end
          end
        end

        GAP: begin
          if (stop_req) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b1;
            stop_pending <= 1'b0;
          end else if (gap_end) begin
            state         <= SEND;
            gap_cnt       <= '0;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (last_beat_q == '0);
          end else begin
            gap_cnt <= gap_cnt + LEN_WIDTH'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_traffic_gen.sv
// -----------------------------------------------------------------------------
// tb_axis_traffic_gen
//   Self-checking bench for axis_traffic_gen. Each scenario task drives a run,
//   records every handshake (data, tlast, cycle) plus busy/done behaviour, and
//   compares against a packet-level model of the expected word stream.
// -----------------------------------------------------------------------------
module tb_axis_traffic_gen;

  localparam int DWIDTH    = 32;
  localparam int LEN_WIDTH = 16;
  localparam int CNT_WIDTH = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 stop;
  logic [LEN_WIDTH-1:0] cfg_pkt_len;
  logic [CNT_WIDTH-1:0] cfg_pkt_num;
  logic [LEN_WIDTH-1:0] cfg_gap;
  logic                 busy;
  logic                 done;
  logic [CNT_WIDTH-1:0] pkt_cnt;
  logic [DWIDTH-1:0]    m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic                 m_axis_tlast;

  int checks   = 0;
  int failures = 0;

  // Observed run record
  logic [DWIDTH-1:0] q_data[$];
  logic              q_last[$];
  int                q_cyc[$];
  int                done_cyc;
  int                done_pulses;
  int                hold_err;
  int                overlap_err;
  int                busy_err;
  bit                done_seen;
  bit                timed_out;
  bit                start_ack;

  // Model output
  logic [DWIDTH-1:0] exp_data[$];
  logic              exp_last[$];
  int                exp_pkts;

  axis_traffic_gen #(
    .DWIDTH   (DWIDTH),
    .LEN_WIDTH(LEN_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .cfg_pkt_len  (cfg_pkt_len),
    .cfg_pkt_num  (cfg_pkt_num),
    .cfg_gap      (cfg_gap),
    .busy         (busy),
    .done         (done),
    .pkt_cnt      (pkt_cnt),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast)
  );

  always #5 clk = ~clk;

  // Packet-level model: a run is npkt packets of L words, words numbered from 0,
  // tlast on every L-th word. A stop during word k finishes packet k/L.
  task automatic build_expected(input int len, input int num, input int stop_beat);
    int l;
    int npkt;
    l = (len == 0) ? 1 : len;
    exp_data.delete();
    exp_last.delete();
    if (stop_beat >= 0) begin
      npkt = stop_beat / l + 1;
      if (num != 0 && num < npkt) npkt = num;
    end else begin
      npkt = num;
    end
    for (int i = 0; i < npkt * l; i++) begin
      exp_data.push_back(DWIDTH'(i));
      exp_last.push_back((i % l) == (l - 1));
    end
    exp_pkts = npkt;
  endtask

  // Drives one run from a start pulse and records what the DUT does.
  // ready_mode: 0 = always ready, 1 = ready every third cycle, 2 = random.
  task automatic run(input int len, input int num, input int gap, input int ready_mode,
                     input int stop_beat, input int restart_iter, input int limit);
    bit                prev_stall = 1'b0;
    logic [DWIDTH-1:0] prev_data  = '0;
    logic              prev_last  = 1'b0;
    bit                hs;
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    done_seen = 0; done_cyc = -1; done_pulses = 0; hold_err = 0;
    overlap_err = 0; busy_err = 0; start_ack = 0; timed_out = 0;
    for (int it = 0; it < limit; it++) begin
      @(negedge clk);
      if (it == 0) begin
        cfg_pkt_len = LEN_WIDTH'(len);
        cfg_pkt_num = CNT_WIDTH'(num);
        cfg_gap     = LEN_WIDTH'(gap);
        start       = 1'b1;
      end else if (it == restart_iter) begin
        cfg_pkt_len = LEN_WIDTH'(5);
        cfg_pkt_num = CNT_WIDTH'(1);
        cfg_gap     = LEN_WIDTH'(1);
        start       = 1'b1;
      end else begin
        start = 1'b0;
      end
      case (ready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ((it % 3) == 0);
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      hs   = m_axis_tvalid && m_axis_tready;
      stop = (stop_beat >= 0) && hs && (q_data.size() == stop_beat);
      if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
        hold_err++;
      if (busy && done) overlap_err++;
      if (it == 1) start_ack = busy && m_axis_tvalid;
      if (it >= 1 && !done_seen && !done && !busy) busy_err++;
      if (done) begin
        done_pulses++;
        if (!done_seen) begin
          done_seen = 1;
          done_cyc  = it;
        end
      end
      if (hs) begin
        q_data.push_back(m_axis_tdata);
        q_last.push_back(m_axis_tlast);
        q_cyc.push_back(it);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      if (done_seen && it >= done_cyc + 2) break;
    end
    start         = 1'b0;
    stop          = 1'b0;
    m_axis_tready = 1'b1;
    timed_out     = !done_seen;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; m_axis_tready = 1'b1;
    cfg_pkt_len = '0; cfg_pkt_num = '0; cfg_gap = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, busy, done} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: valid/last/busy/done=%b required 0000",
               {m_axis_tvalid, m_axis_tlast, busy, done});
    end
    checks++;
    if (m_axis_tdata !== '0 || pkt_cnt !== '0) begin
      failures++;
      $display("[TB] FAIL reset_data: tdata=%0h pkt_cnt=%0d required 0/0", m_axis_tdata, pkt_cnt);
    end
    rst_n = 1'b1;
    // stop while idle must not be remembered by the next run
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || m_axis_tvalid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_stop: busy=%b valid=%b done=%b required 0/0/0", busy, m_axis_tvalid, done);
    end
  endtask

  task automatic test_back_to_back();
    run(4, 2, 0, 0, -1, -1, 100);
    build_expected(4, 2, -1);
    checks++;
    if (timed_out) begin failures++; $display("[TB] FAIL b2b_timeout: done never seen"); end
    checks++;
    if (!start_ack) begin failures++; $display("[TB] FAIL b2b_start_latency: busy&valid=0 required 1"); end
    checks++;
    if (q_data.size() != exp_data.size()) begin
      failures++;
      $display("[TB] FAIL b2b_beats: got %0d required %0d", q_data.size(), exp_data.size());
    end
    for (int i = 0; i < q_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (q_data[i] !== exp_data[i] || q_last[i] !== exp_last[i]) begin
        failures++;
        $display("[TB] FAIL b2b_beat%0d: data=%0h last=%b required %0h/%b", i, q_data[i], q_last[i], exp_data[i], exp_last[i]);
      end
      if (i > 0) begin
        checks++;
        if (q_cyc[i] != q_cyc[i-1] + 1) begin
          failures++;
          $display("[TB] FAIL b2b_spacing%0d: delta=%0d required 1", i, q_cyc[i] - q_cyc[i-1]);
        end
      end
    end
    checks++;
    if (q_cyc.size() > 0 && done_cyc != q_cyc[q_cyc.size()-1] + 1) begin
      failures++;
      $display("[TB] FAIL b2b_done_time: cycle=%0d required %0d", done_cyc, q_cyc[q_cyc.size()-1] + 1);
    end
    checks++;
    if (pkt_cnt !== CNT_WIDTH'(exp_pkts) || done_pulses != 1) begin
      failures++;
      $display("[TB] FAIL b2b_status: pkt_cnt=%0d done_pulses=%0d required %0d/1", pkt_cnt, done_pulses, exp_pkts);
    end
    checks++;
    if (overlap_err != 0 || busy_err != 0) begin
      failures++;
      $display("[TB] FAIL b2b_busy: overlap=%0d busy_drop=%0d required 0/0", overlap_err, busy_err);
    end
  endtask

  task automatic test_gap();
    int delta;
    run(3, 2, 2, 0, -1, -1, 100);
    build_expected(3, 2, -1);
    checks++;
    if (timed_out || q_data.size() != exp_data.size()) begin
      failures++;
      $display("[TB] FAIL gap_beats: got %0d timeout=%b required %0d/0", q_data.size(), timed_out, exp_data.size());
    end
    for (int i = 0; i < q_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (q_data[i] !== exp_data[i] || q_last[i] !== exp_last[i]) begin
        failures++;
        $display("[TB] FAIL gap_beat%0d: data=%0h last=%b required %0h/%b", i, q_data[i], q_last[i], exp_data[i], exp_last[i]);
      end
      if (i > 0) begin
        delta = exp_last[i-1] ? 3 : 1;
        checks++;
        if (q_cyc[i] - q_cyc[i-1] != delta) begin
          failures++;
          $display("[TB] FAIL gap_spacing%0d: delta=%0d required %0d", i, q_cyc[i] - q_cyc[i-1], delta);
        end
      end
    end
    checks++;
    if (busy_err != 0 || pkt_cnt !== CNT_WIDTH'(2)) begin
      failures++;
      $display("[TB] FAIL gap_status: busy_drop=%0d pkt_cnt=%0d required 0/2", busy_err, pkt_cnt);
    end
  endtask

  task automatic test_backpressure();
    run(5, 1, 0, 1, -1, -1, 200);
    build_expected(5, 1, -1);
    checks++;
    if (timed_out || q_data.size() != exp_data.size()) begin
      failures++;
      $display("[TB] FAIL bp_beats: got %0d timeout=%b required %0d/0", q_data.size(), timed_out, exp_data.size());
    end
    for (int i = 0; i < q_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (q_data[i] !== exp_data[i] || q_last[i] !== exp_last[i]) begin
        failures++;
        $display("[TB] FAIL bp_beat%0d: data=%0h last=%b required %0h/%b", i, q_data[i], q_last[i], exp_data[i], exp_last[i]);
      end
    end
    checks++;
    if (hold_err != 0) begin failures++; $display("[TB] FAIL bp_hold: violations=%0d required 0", hold_err); end
    checks++;
    if (pkt_cnt !== CNT_WIDTH'(1) || done_pulses != 1) begin
      failures++;
      $display("[TB] FAIL bp_status: pkt_cnt=%0d done_pulses=%0d required 1/1", pkt_cnt, done_pulses);
    end
  endtask

  task automatic test_stop();
    run(2, 0, 0, 0, 6, -1, 200);
    build_expected(2, 0, 6);
    checks++;
    if (timed_out || q_data.size() != exp_data.size()) begin
      failures++;
      $display("[TB] FAIL stop_beats: got %0d timeout=%b required %0d/0", q_data.size(), timed_out, exp_data.size());
    end
    for (int i = 0; i < q_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (q_data[i] !== exp_data[i] || q_last[i] !== exp_last[i]) begin
        failures++;
        $display("[TB] FAIL stop_beat%0d: data=%0h last=%b required %0h/%b", i, q_data[i], q_last[i], exp_data[i], exp_last[i]);
      end
    end
    checks++;
    if (pkt_cnt !== CNT_WIDTH'(exp_pkts) || done_pulses != 1 || overlap_err != 0) begin
      failures++;
      $display("[TB] FAIL stop_status: pkt_cnt=%0d done_pulses=%0d overlap=%0d required %0d/1/0", pkt_cnt, done_pulses, overlap_err, exp_pkts);
    end
  endtask

  task automatic test_zero_len_restart();
    run(0, 3, 0, 0, -1, 2, 100);
    build_expected(0, 3, -1);
    checks++;
    if (timed_out || q_data.size() != exp_data.size()) begin
      failures++;
      $display("[TB] FAIL zlen_beats: got %0d timeout=%b required %0d/0", q_data.size(), timed_out, exp_data.size());
    end
    for (int i = 0; i < q_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (q_data[i] !== exp_data[i] || q_last[i] !== exp_last[i]) begin
        failures++;
        $display("[TB] FAIL zlen_beat%0d: data=%0h last=%b required %0h/%b", i, q_data[i], q_last[i], exp_data[i], exp_last[i]);
      end
    end
    checks++;
    if (pkt_cnt !== CNT_WIDTH'(3)) begin
      failures++;
      $display("[TB] FAIL zlen_pkt_cnt: got %0d required 3", pkt_cnt);
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    cfg_pkt_len = LEN_WIDTH'(8); cfg_pkt_num = CNT_WIDTH'(1); cfg_gap = '0;
    m_axis_tready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (m_axis_tvalid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_pre: valid=%b busy=%b required 1/1", m_axis_tvalid, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || pkt_cnt !== '0 || m_axis_tdata !== '0) begin
      failures++;
      $display("[TB] FAIL rst_async: valid=%b busy=%b pkt_cnt=%0d tdata=%0h required 0/0/0/0", m_axis_tvalid, busy, pkt_cnt, m_axis_tdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run(2, 1, 0, 0, -1, -1, 50);
    checks++;
    if (timed_out || q_data.size() != 2 || q_data[0] !== '0) begin
      failures++;
      $display("[TB] FAIL rst_resume: beats=%0d first=%0h required 2/0", q_data.size(), (q_data.size() > 0) ? q_data[0] : 'x);
    end
  endtask

  task automatic test_random();
    int len;
    int num;
    int gap;
    for (int r = 0; r < 5; r++) begin
      len = int'($urandom_range(0, 5));
      num = int'($urandom_range(1, 4));
      gap = int'($urandom_range(0, 3));
      run(len, num, gap, 2, -1, -1, 600);
      build_expected(len, num, -1);
      checks++;
      if (timed_out || q_data.size() != exp_data.size()) begin
        failures++;
        $display("[TB] FAIL rnd%0d_beats: got %0d timeout=%b required %0d/0 (len=%0d num=%0d gap=%0d)", r, q_data.size(), timed_out, exp_data.size(), len, num, gap);
      end
      for (int i = 0; i < q_data.size() && i < exp_data.size(); i++) begin
        checks++;
        if (q_data[i] !== exp_data[i] || q_last[i] !== exp_last[i]) begin
          failures++;
          $display("[TB] FAIL rnd%0d_beat%0d: data=%0h last=%b required %0h/%b", r, i, q_data[i], q_last[i], exp_data[i], exp_last[i]);
        end
        if (i > 0 && exp_last[i-1]) begin
          checks++;
          if (q_cyc[i] - q_cyc[i-1] < gap + 1) begin
            failures++;
            $display("[TB] FAIL rnd%0d_gap%0d: delta=%0d required >=%0d", r, i, q_cyc[i] - q_cyc[i-1], gap + 1);
          end
        end
      end
      checks++;
      if (hold_err != 0 || pkt_cnt !== CNT_WIDTH'(exp_pkts) || done_pulses != 1) begin
        failures++;
        $display("[TB] FAIL rnd%0d_status: hold=%0d pkt_cnt=%0d done_pulses=%0d required 0/%0d/1", r, hold_err, pkt_cnt, done_pulses, exp_pkts);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gap();
    test_backpressure();
    test_stop();
    test_zero_len_restart();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a hung simulation
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
